// File: rtl/sram_line_write_combiner.sv
// sram_line_write_combiner
// Gathers single-pixel writes from the rasterizer into one resident SRAM line.
// A miss triggers a write-back of the dirty line (if any) and then a full-line
// fetch of the new line. A flush writes back the dirty line and pulses flush_done.
// The SRAM only ever sees aligned whole-line accesses, and read and write strobes
// never overlap.
// Build option: define LINE_COMBINER_PERF_EN to enable the hit/miss counters.
// When it is left undefined, both counters read as zero.
//
// Handshake: a pixel transfers on any rising edge where px_valid && px_ready.
// The requester holds px_addr/px_data stable while px_valid is high and
// px_ready is low. A missing pixel is therefore taken as a hit once the new
// line is resident.
`timescale 1ns/1ps
module sram_line_write_combiner #(
    parameter int ADDR_BITS      = 16,
    parameter int WORDS_PER_LINE = 64,
    parameter int WORD_BITS      = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                px_valid,
    output logic                                px_ready,
    input  logic [ADDR_BITS-1:0]                px_addr,
    input  logic [WORD_BITS-1:0]                px_data,
    input  logic                                flush_req,
    output logic                                flush_done,
    output logic                                busy,
    output logic                                read_enable,
    output logic                                write_enable,
    output logic [ADDR_BITS-1:0]                address,
    output logic [WORDS_PER_LINE*WORD_BITS-1:0] write_data,
    input  logic [WORDS_PER_LINE*WORD_BITS-1:0] read_data,
    output logic [15:0]                         hit_count,
    output logic [15:0]                         miss_count,
    output logic [2:0]                          dbg_state_o
);
    localparam int OFF_BITS  = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS  = ADDR_BITS - OFF_BITS;
    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRBACK    = 3'd1,
        S_FETCH     = 3'd2,
        S_FLUSH_WB  = 3'd3,
        S_FLUSH_ACK = 3'd4
    } state_t;

    state_t                    state_q;
    logic [LINE_BITS-1:0]      line_q;
    logic [WORDS_PER_LINE-1:0] dirty_q;
    logic [TAG_BITS-1:0]       tag_q;
    logic                      tag_valid_q;
    logic [TAG_BITS-1:0]       miss_tag_q;
    logic                      re_q;
    logic                      we_q;
    logic [ADDR_BITS-1:0]      addr_q;
    logic [LINE_BITS-1:0]      wdata_q;
    logic                      fdone_q;

    logic [TAG_BITS-1:0]       px_tag;
    logic [OFF_BITS-1:0]       px_off;
    logic                      idle;
    logic                      tag_match;
    logic                      flush_take;
    logic                      hit_take;
    logic                      miss_take;

    assign px_tag = px_addr[ADDR_BITS-1:OFF_BITS];
    assign px_off = px_addr[OFF_BITS-1:0];

    // Request decode: flush wins over a pixel; a miss drops px_ready in the same cycle.
    always_comb begin
        idle       = (state_q == S_IDLE) && !rst;
        tag_match  = tag_valid_q && (px_tag == tag_q);
        flush_take = idle && flush_req;
        hit_take   = idle && !flush_req && px_valid && tag_match;
        miss_take  = idle && !flush_req && px_valid && !tag_match;
        px_ready   = idle && !flush_req && (!px_valid || tag_match);
    end

    // Control FSM plus line buffer. Strobes, address and data are one-cycle registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dirty_q     <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            miss_tag_q  <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fdone_q     <= 1'b0;
        end else begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fdone_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (flush_take) begin
                        if (|dirty_q) begin
                            state_q <= S_FLUSH_WB;
                            we_q    <= 1'b1;
                            addr_q  <= {tag_q, {OFF_BITS{1'b0}}};
                            wdata_q <= line_q;
                        end else begin
                            state_q <= S_FLUSH_ACK;
                            fdone_q <= 1'b1;
                        end
                    end else if (hit_take) begin
                        line_q[px_off*WORD_BITS +: WORD_BITS] <= px_data;
                        dirty_q[px_off]                        <= 1'b1;
                    end else if (miss_take) begin
                        miss_tag_q <= px_tag;
                        if (|dirty_q) begin
                            state_q <= S_WRBACK;
                            we_q    <= 1'b1;
                            addr_q  <= {tag_q, {OFF_BITS{1'b0}}};
                            wdata_q <= line_q;
                        end else begin
                            state_q <= S_FETCH;
                            re_q    <= 1'b1;
                            addr_q  <= {px_tag, {OFF_BITS{1'b0}}};
                        end
                    end
                end
                S_WRBACK: begin
                    dirty_q <= '0;
                    state_q <= S_FETCH;
                    re_q    <= 1'b1;
                    addr_q  <= {miss_tag_q, {OFF_BITS{1'b0}}};
                end
                S_FETCH: begin
                    line_q      <= read_data;
                    tag_q       <= miss_tag_q;
                    tag_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_FLUSH_WB: begin
                    dirty_q <= '0;
                    state_q <= S_FLUSH_ACK;
                    fdone_q <= 1'b1;
                end
                S_FLUSH_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign read_enable  = re_q;
    assign write_enable = we_q;
    assign address      = addr_q;
    assign write_data   = wdata_q;
    assign flush_done   = fdone_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;

`ifdef LINE_COMBINER_PERF_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] hit_cnt_d;
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;
    logic        replay_q;
    logic        replay_d;

    // Counter next-state. The hit that completes a miss is a replay and is not counted.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        replay_d   = replay_q;
        if (miss_take) begin
            replay_d = 1'b1;
            if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
        if (hit_take) begin
            replay_d = 1'b0;
            if (!replay_q && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end
        end
    end

    // Saturating performance counters, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            replay_q   <= replay_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_sram_line_write_combiner.sv
// Bench for sram_line_write_combiner. Directed table, reset-abort sequence,
// then randomized pixels and flushes scored against a word-level memory image.
`timescale 1ns/1ps
module tb_sram_line_write_combiner;
    localparam int LB = 64 * 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          px_valid;
    logic          px_ready;
    logic [15:0]   px_addr;
    logic [23:0]   px_data;
    logic          flush_req;
    logic          flush_done;
    logic          busy;
    logic          read_enable;
    logic          write_enable;
    logic [15:0]   address;
    logic [LB-1:0] write_data;
    logic [LB-1:0] read_data;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
    logic [2:0]    dbg_state;

    sram_line_write_combiner dut (
        .clk(clk), .rst(rst),
        .px_valid(px_valid), .px_ready(px_ready), .px_addr(px_addr), .px_data(px_data),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .read_enable(read_enable), .write_enable(write_enable), .address(address),
        .write_data(write_data), .read_data(read_data),
        .hit_count(hit_count), .miss_count(miss_count), .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];          // expected write-back line addresses, in order
    logic [23:0] sram_w [int];      // SRAM model, word-addressed
    logic [23:0] ref_mem [int];     // every accepted pixel, word-addressed
    bit          touched [int];     // lines ever written by a pixel
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          fd_cnt = 0;
    int          n_flush = 0;
    logic [15:0] last_we_addr = '0;
    logic [15:0] last_re_addr = '0;
    logic [LB-1:0] first_wb_data = '0;
    // abstract model of the combiner: which line is resident and whether it holds writes
    bit          model_valid = 0;
    int          model_line = 0;
    bit          model_dirty = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] init_word(input int a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:8];
    endfunction

    function automatic logic [23:0] sram_rd(input int a);
        if (sram_w.exists(a)) return sram_w[a];
        return init_word(a);
    endfunction

    function automatic logic [23:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // SRAM model and per-cycle protocol checks, sampled mid-cycle
    always @(negedge clk) begin
        chk("strobe_exclusive", {1'b0, read_enable && write_enable}, 0);
        if (read_enable || write_enable) chk("strobe_aligned", address[5:0], 0);
        if (write_enable) begin
            if (we_cnt == 0) first_wb_data = write_data;
            we_cnt++;
            last_we_addr = address;
            for (int i = 0; i < 64; i++) sram_w[int'(address) + i] = write_data[i*24 +: 24];
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected actual=%0h required=none @%0t", address, $time);
            end else begin
                chk("wb_addr", address, exp_q.pop_front());
            end
        end
        if (read_enable) begin
            re_cnt++;
            last_re_addr = address;
            for (int i = 0; i < 64; i++) read_data[i*24 +: 24] = sram_rd(int'(address) + i);
        end else begin
            read_data = '0;
        end
        if (flush_done) fd_cnt++;
    end

    // ---------------- reference model ----------------
    task automatic model_px(input logic [15:0] a, output int w);
        int ln;
        ln = int'(a >> 6);
        if (model_valid && ln == model_line) begin
            w = 0;
            exp_hits++;
        end else begin
            w = model_dirty ? 3 : 2;
            if (model_dirty) exp_q.push_back(16'(model_line << 6));
            exp_misses++;
        end
        model_valid = 1;
        model_line  = ln;
        model_dirty = 1;
    endtask

    task automatic model_flush(output int lat);
        lat = model_dirty ? 2 : 1;
        if (model_dirty) exp_q.push_back(16'(model_line << 6));
        model_dirty = 0;
    endtask

    // ---------------- drivers ----------------
    // entered and left at posedge+1; counts cycles px_ready stayed low
    task automatic send_px(input logic [15:0] a, input logic [23:0] d, output int waited);
        bit ok;
        px_valid = 1'b1;
        px_addr  = a;
        px_data  = d;
        waited   = 0;
        ok       = 0;
        while (!ok && waited <= 20) begin
            @(negedge clk);
            if (px_ready) ok = 1;
            else waited++;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            ref_mem[int'(a)] = d;
            touched[int'(a >> 6)] = 1;
        end else begin
            total++;
            bad++;
            $display("FAIL px_timeout actual=stalled required=accept addr=%0h", a);
        end
        px_valid = 1'b0;
    endtask

    task automatic do_flush(output int lat);
        bit seen;
        n_flush++;
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        seen = 0;
        lat  = 1;
        while (!seen && lat <= 10) begin
            @(negedge clk);
            if (flush_done) seen = 1;
            @(posedge clk);
            #1;
            if (!seen) lat++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL flush_timeout actual=no_done required=done");
        end
    endtask

    // ---------------- directed table ----------------
    localparam int K_PX = 0, K_BURST = 1, K_FLUSH = 2;
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [23:0] data;
        int          exp_lat;
        int          exp_wb;
        logic [15:0] exp_wb_addr;
    } vec_t;
    vec_t tbl[9];

    logic [15:0] ra;
    int          w, ew, lat, el, we0, re0, fd0, sum;

    initial begin
        tbl[0] = '{K_PX,    16'h0005, 24'hABCDEF, 2, 0, 16'h0000};
        tbl[1] = '{K_BURST, 16'h0000, 24'h000000, 0, 0, 16'h0000};
        tbl[2] = '{K_PX,    16'h0040, 24'h111111, 3, 1, 16'h0000};
        tbl[3] = '{K_PX,    16'h0041, 24'h222222, 0, 0, 16'h0000};
        tbl[4] = '{K_FLUSH, 16'h0000, 24'h000000, 2, 1, 16'h0040};
        tbl[5] = '{K_FLUSH, 16'h0000, 24'h000000, 1, 0, 16'h0000};
        tbl[6] = '{K_PX,    16'h0042, 24'h333333, 0, 0, 16'h0000};
        tbl[7] = '{K_PX,    16'hFFC7, 24'h444444, 3, 1, 16'h0040};
        tbl[8] = '{K_FLUSH, 16'h0000, 24'h000000, 2, 1, 16'hFFC0};

        rst = 1'b1; px_valid = 1'b0; px_addr = '0; px_data = '0; flush_req = 1'b0;
        read_data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_px_ready", px_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_read_enable", read_enable, 0);
        chk("rst_write_enable", write_enable, 0);
        chk("rst_address", address, 0);
        chk("rst_write_data_zero", {63'd0, write_data == '0}, 1);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", px_ready, 1);
        @(posedge clk);
        #1;

        for (int k = 0; k < 9; k++) begin
            we0 = we_cnt; re0 = re_cnt; fd0 = fd_cnt;
            if (tbl[k].kind == K_PX) begin
                model_px(tbl[k].addr, ew);
                send_px(tbl[k].addr, tbl[k].data, w);
                chk($sformatf("t%0d_wait", k), w, tbl[k].exp_lat);
                chk($sformatf("t%0d_wb_count", k), we_cnt - we0, tbl[k].exp_wb);
                if (tbl[k].exp_wb != 0) chk($sformatf("t%0d_wb_addr", k), last_we_addr, tbl[k].exp_wb_addr);
                chk($sformatf("t%0d_rd_count", k), re_cnt - re0, (tbl[k].exp_lat > 0) ? 1 : 0);
                if (tbl[k].exp_lat > 0) chk($sformatf("t%0d_rd_addr", k), last_re_addr, tbl[k].addr & 16'hFFC0);
            end else if (tbl[k].kind == K_BURST) begin
                sum = 0;
                for (int i = 0; i < 64; i++) begin
                    model_px(tbl[k].addr + 16'(i), ew);
                    send_px(tbl[k].addr + 16'(i), (i == 5) ? 24'hABCDEF : {8'h5A, 16'(i)}, w);
                    sum += w;
                end
                chk("burst_stall_cycles", sum, 0);
                chk("burst_no_strobes", (we_cnt - we0) + (re_cnt - re0), 0);
            end else begin
                model_flush(el);
                do_flush(lat);
                chk($sformatf("t%0d_flush_lat", k), lat, tbl[k].exp_lat);
                chk($sformatf("t%0d_flush_wb", k), we_cnt - we0, tbl[k].exp_wb);
                if (tbl[k].exp_wb != 0) chk($sformatf("t%0d_flush_wb_addr", k), last_we_addr, tbl[k].exp_wb_addr);
                chk($sformatf("t%0d_flush_done", k), fd_cnt - fd0, 1);
            end
        end
        chk("wb_word5", first_wb_data[5*24 +: 24], 24'hABCDEF);
`ifdef LINE_COMBINER_PERF_EN
        chk("tbl_miss_count", miss_count, exp_misses);
        chk("tbl_hit_count", hit_count, exp_hits);
`else
        chk("tbl_miss_count_tied", miss_count, 0);
        chk("tbl_hit_count_tied", hit_count, 0);
`endif

        // ---- reset asserted during WRBACK ----
        model_px(16'h1234, ew);
        send_px(16'h1234, 24'hC0FFEE, w);
        chk("pre_rst_wait", w, ew);
        exp_q.push_back(16'h1200);
        px_valid = 1'b1; px_addr = 16'h2000; px_data = 24'h777777;
        @(negedge clk);
        chk("miss_ready_low", px_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; px_valid = 1'b0;
        @(negedge clk);
        chk("wrback_we", write_enable, 1);
        chk("wrback_busy", busy, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_we", write_enable, 0);
        chk("abort_re", read_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", px_ready, 0);
        we0 = we_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_valid = 0; model_dirty = 0; exp_hits = 0; exp_misses = 0;
        model_px(16'h1234, ew);
        send_px(16'h1234, 24'h0BADF0, w);
        chk("post_rst_wait", w, 2);
        chk("post_rst_no_wb", we_cnt - we0, 0);
        chk("post_rst_fetch_addr", last_re_addr, 16'h1200);

        // ---- randomized traffic ----
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                model_flush(el);
                do_flush(lat);
                chk("rnd_flush_lat", lat, el);
            end else begin
                case ($urandom_range(0, 3))
                    0: ra = {10'h000, 6'($urandom)};
                    1: ra = {10'h001, 6'($urandom)};
                    2: ra = {10'h3FF, 6'($urandom)};
                    default: ra = 16'($urandom);
                endcase
                model_px(ra, ew);
                send_px(ra, 24'($urandom), w);
                chk("rnd_wait", w, ew);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        model_flush(el);
        do_flush(lat);
        chk("final_flush_lat", lat, el);

        foreach (touched[ln]) begin
            int bw;
            bw = -1;
            for (int i = 0; i < 64; i++)
                if (bw < 0 && sram_rd(ln * 64 + i) !== ref_rd(ln * 64 + i)) bw = i;
            if (bw < 0) bw = 0;
            chk($sformatf("line_image_%0h", ln * 64 + bw), sram_rd(ln * 64 + bw), ref_rd(ln * 64 + bw));
        end
        chk("flush_done_pulses", fd_cnt, n_flush);
        chk("wb_queue_drained", exp_q.size(), 0);
`ifdef LINE_COMBINER_PERF_EN
        chk("rnd_miss_count", miss_count, exp_misses);
        chk("rnd_hit_count", hit_count, exp_hits);
`else
        chk("rnd_miss_count_tied", miss_count, 0);
        chk("rnd_hit_count_tied", hit_count, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_line_write_combiner.md
Name: sram_line_write_combiner

Overview:
- Sits directly upstream of the on-chip SRAM wrapper in the 2D GPU framebuffer path.
- Accepts single 24-bit pixel writes from the rasterizer.
- Combines them into one 64-word (1536-bit) line buffer and issues full-line SRAM accesses.
- Performs a line read on a miss and a line write-back on eviction or flush, so the SRAM sees only aligned 64-word transfers with never-overlapping read/write enables.

Parameters:
- ADDR_BITS, 16, SRAM word-address width.
- WORDS_PER_LINE, 64, words per SRAM access; power of two.
- WORD_BITS, 24, bits per word (one RGB pixel).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- px_valid  in  1  pixel write request valid.
- px_ready  out  1  pixel accepted on a cycle with px_valid && px_ready.
- px_addr  in  ADDR_BITS  pixel word address.
- px_data  in  WORD_BITS  pixel value.
- flush_req  in  1  single-cycle request to write back the dirty line.
- flush_done  out  1  one-cycle pulse when the flush completes.
- busy  out  1  high in any state other than IDLE.
- read_enable  out  1  SRAM read strobe.
- write_enable  out  1  SRAM write strobe.
- address  out  ADDR_BITS  SRAM line base address; low log2(WORDS_PER_LINE) bits are always 0.
- write_data  out  WORDS_PER_LINE*WORD_BITS  line write data.
- read_data  in  WORDS_PER_LINE*WORD_BITS  line read data.
- hit_count  out  16  performance counter (see Optional Feature).
- miss_count  out  16  performance counter (see Optional Feature).

Behaviour:
- Interface decisions: one clock; reset is synchronous and active-high.
- Word/bit mapping: word i of a line occupies bits [i*WORD_BITS +: WORD_BITS]. Word 0 is at the LSBs.
- Internal state:
  - line_buf: WORDS_PER_LINE x WORD_BITS.
  - dirty: WORDS_PER_LINE bits; set per word written, cleared on write-back.
  - tag: ADDR_BITS-6 bits.
  - tag_valid.
- Reset: state IDLE; tag_valid=0, dirty=0.
  - Outputs: px_ready=0, flush_done=0, busy=0, read_enable=0, write_enable=0, address=0, write_data=0.
  - px_ready rises the first cycle after rst deasserts.
- Reset asserted mid-operation aborts in that cycle. Dirty data is discarded and all strobes drop the next edge.
- FSM states: IDLE, WRBACK, FETCH, FLUSH_WB, FLUSH_ACK.
- IDLE:
  - px_ready = 1 unless flush_req is high.
  - Hit (tag_valid and px_addr[15:6]==tag): write px_data into line_buf[px_addr[5:0]] and set its dirty bit. Accepted in the same cycle; zero-bubble throughput of 1 pixel/cycle.
  - Miss: px_ready=0 combinationally that cycle.
    - If any dirty bit is set, go to WRBACK.
    - Otherwise go to FETCH.
  - The miss pixel stays pending (rasterizer holds it) and is accepted as a hit on return to IDLE.
- WRBACK (1 cycle):
  - write_enable=1, address={tag,6'b0}, write_data=line_buf.
  - Clear dirty, then go to FETCH.
- FETCH (1 cycle):
  - read_enable=1, address={px_addr[15:6],6'b0}.
  - read_data is sampled at the closing edge (SRAM access < 1 clock) into line_buf.
  - tag<=px_addr[15:6], tag_valid<=1, then go to IDLE.
- Miss latency: 2 cycles clean, 3 cycles dirty, counted from miss detect to px_ready.
- flush_req in IDLE has priority over px_valid that cycle.
  - dirty != 0: FLUSH_WB (same strobes as WRBACK), then FLUSH_ACK.
  - dirty == 0: go straight to FLUSH_ACK.
  - FLUSH_ACK: flush_done=1 for one cycle, then IDLE. tag_valid is retained.
- flush_req outside IDLE is ignored; the requester must retry.
- read_enable and write_enable are never high in the same cycle. Strobes and address/write_data are registered outputs, valid for exactly one cycle.
- Address wrap: px_addr spans the full ADDR_BITS range with no wrap logic. The line base is always aligned.

Optional Feature:
- Macro: LINE_COMBINER_PERF_EN.
- Defined:
  - hit_count increments on each accepted hit that was not immediately preceded by a miss of the same pixel.
  - miss_count increments on each miss detect.
  - Both counters are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: hit_count and miss_count are tied to 0 and no counter flops exist.

Test Plan:
- Reset then px_valid at addr 0x0005 data 0xABCDEF -> miss, FETCH read_enable with address 0x0000, px_ready after 2 cycles, no write_enable.
- Then pixels at 0x0000..0x003F back-to-back -> px_ready held 1, 64 accepts in 64 cycles, no SRAM strobes.
- Pixel at 0x0040 with the line dirty -> WRBACK write_enable at address 0x0000 with write_data word 5 = 0xABCDEF, then FETCH at 0x0040; px_ready after 3 cycles.
- flush_req with dirty word -> one write_enable, then flush_done pulse exactly 2 cycles after the request. Repeat flush_req when clean -> flush_done 1 cycle later, no write.
- rst asserted during WRBACK -> strobes low next cycle, tag_valid=0, next pixel triggers FETCH without write-back.
- Every cycle checker: !(read_enable && write_enable), and address[5:0]==0 whenever a strobe is high. With LINE_COMBINER_PERF_EN after the above sequence -> miss_count=2 and hit_count matches accepted hits.
